// File: rtl/tcm_pkg.sv
// Shared definitions for the TCM port arbiter.
//   TCM_SIZE     byte size of the TCM window (128KB)
//   TCM_WORD_AW  width of the RAM 64-bit word address
//   LANE_BIT     byte-address bit that selects the upper 32-bit lane
//   port_e       port identifiers used by the arbiter and response stage
//   lane_be      steers 4 port byte enables onto the 8 RAM byte enables
package tcm_pkg;

    localparam logic [31:0] TCM_SIZE    = 32'h0002_0000;
    localparam int unsigned TCM_WORD_AW = 14;
    localparam int unsigned LANE_BIT    = 2;
    localparam int unsigned WORD_LSB    = 3;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    function automatic logic [7:0] lane_be(input logic hi, input logic [3:0] be);
        return hi ? {be, 4'b0000} : {4'b0000, be};
    endfunction

endpackage

// File: rtl/tcm_port_arb_rr.sv
// Two-way round-robin arbiter. The priority pointer moves only when both
// ports request in the same cycle; a lone requester is granted directly.
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_a_i, req_b_i    request from port A / port B
//   gnt_a_o, gnt_b_o    one-hot (or zero) grant; forced 0 during reset
module tcm_port_arb_rr
    import tcm_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_a_i,
    input  logic req_b_i,
    output logic gnt_a_o,
    output logic gnt_b_o
);

    // Port favoured on the next contended cycle.
    port_e prio_q, prio_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= PORT_A;
        end else begin
            prio_q <= prio_d;
        end
    end

    always_comb begin
        gnt_a_o = 1'b0;
        gnt_b_o = 1'b0;
        prio_d  = prio_q;
        if (!rst_i) begin
            if (req_a_i && req_b_i) begin
                if (prio_q == PORT_A) begin
                    gnt_a_o = 1'b1;
                    prio_d  = PORT_B;
                end else begin
                    gnt_b_o = 1'b1;
                    prio_d  = PORT_A;
                end
            end else begin
                gnt_a_o = req_a_i;
                gnt_b_o = req_b_i;
            end
        end
    end

endmodule

// File: rtl/tcm_port_arb.sv
// Arbitrates two 32-bit request/response ports onto one 64-bit TCM RAM port.
// Steers 32-bit data/byte enables into the correct RAM lane, range-checks
// addresses against the TCM window, and returns a tagged ack one cycle after
// accept, aligned with the RAM's registered read data.
//   a_* / b_*        port A (core data) / port B (loader/DMA) request/response
//   ram_addr_o       RAM 64-bit word address
//   ram_data_wr_o    RAM write data (32-bit word replicated on both lanes)
//   ram_wr_o         RAM byte write enables
//   ram_data_rd_i    RAM read data, valid 1 cycle after the address
module tcm_port_arb
    import tcm_pkg::*;
#(
    parameter logic [31:0] TCM_BASE = 32'h8000_0000,
    parameter int unsigned TAG_W    = 11
) (
    input  logic                   clk_i,
    input  logic                   rst_i,

    input  logic                   a_rd_i,
    input  logic [3:0]             a_wr_i,
    input  logic [31:0]            a_addr_i,
    input  logic [31:0]            a_data_wr_i,
    input  logic [TAG_W-1:0]       a_tag_i,
    output logic                   a_accept_o,
    output logic                   a_ack_o,
    output logic                   a_error_o,
    output logic [31:0]            a_data_rd_o,
    output logic [TAG_W-1:0]       a_resp_tag_o,

    input  logic                   b_rd_i,
    input  logic [3:0]             b_wr_i,
    input  logic [31:0]            b_addr_i,
    input  logic [31:0]            b_data_wr_i,
    input  logic [TAG_W-1:0]       b_tag_i,
    output logic                   b_accept_o,
    output logic                   b_ack_o,
    output logic                   b_error_o,
    output logic [31:0]            b_data_rd_o,
    output logic [TAG_W-1:0]       b_resp_tag_o,

    output logic [TCM_WORD_AW-1:0] ram_addr_o,
    output logic [63:0]            ram_data_wr_o,
    output logic [7:0]             ram_wr_o,
    input  logic [63:0]            ram_data_rd_i
);

    logic a_req, b_req, gnt_a, gnt_b, gnt_any;

    assign a_req = a_rd_i | (|a_wr_i);
    assign b_req = b_rd_i | (|b_wr_i);

    tcm_port_arb_rr u_rr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_a_i (a_req),
        .req_b_i (b_req),
        .gnt_a_o (gnt_a),
        .gnt_b_o (gnt_b)
    );

    assign a_accept_o = gnt_a;
    assign b_accept_o = gnt_b;
    assign gnt_any    = gnt_a | gnt_b;

    // Granted request mux.
    logic [31:0]      sel_addr, sel_wdata, offset;
    logic [3:0]       sel_wr;
    logic [TAG_W-1:0] sel_tag;
    logic             in_range;

    always_comb begin
        sel_addr  = gnt_b ? b_addr_i    : a_addr_i;
        sel_wdata = gnt_b ? b_data_wr_i : a_data_wr_i;
        sel_wr    = gnt_b ? b_wr_i      : a_wr_i;
        sel_tag   = gnt_b ? b_tag_i     : a_tag_i;
    end

    // Modulo-2^32 subtraction makes addresses below the base wrap to a large
    // offset, so one unsigned compare covers both window edges.
    assign offset   = sel_addr - TCM_BASE;
    assign in_range = offset < TCM_SIZE;

    always_comb begin
        ram_addr_o    = '0;
        ram_data_wr_o = '0;
        ram_wr_o      = '0;
        if (gnt_any && in_range) begin
            ram_addr_o    = offset[16:WORD_LSB];
            ram_data_wr_o = {sel_wdata, sel_wdata};
            ram_wr_o      = lane_be(sel_addr[LANE_BIT], sel_wr);
        end
    end

    // Response stage, aligned with the RAM's registered read data.
    logic             resp_valid_q, resp_valid_d;
    port_e            resp_port_q, resp_port_d;
    logic [TAG_W-1:0] resp_tag_q, resp_tag_d;
    logic             resp_hi_q, resp_hi_d;
    logic             resp_err_q, resp_err_d;

    always_comb begin
        resp_valid_d = gnt_any;
        resp_port_d  = gnt_b ? PORT_B : PORT_A;
        resp_tag_d   = sel_tag;
        resp_hi_d    = sel_addr[LANE_BIT];
        resp_err_d   = !in_range;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_valid_q <= 1'b0;
            resp_port_q  <= PORT_A;
            resp_tag_q   <= '0;
            resp_hi_q    <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_port_q  <= resp_port_d;
            resp_tag_q   <= resp_tag_d;
            resp_hi_q    <= resp_hi_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Gating on rst_i drops a response already registered when reset arrives.
    logic        ack_live, ack_a, ack_b;
    logic [31:0] rdata;

    assign ack_live = resp_valid_q && !rst_i;
    assign ack_a    = ack_live && (resp_port_q == PORT_A);
    assign ack_b    = ack_live && (resp_port_q == PORT_B);
    assign rdata    = resp_err_q ? 32'h0 :
                      (resp_hi_q ? ram_data_rd_i[63:32] : ram_data_rd_i[31:0]);

    always_comb begin
        a_ack_o      = ack_a;
        a_error_o    = ack_a && resp_err_q;
        a_data_rd_o  = ack_a ? rdata : '0;
        a_resp_tag_o = ack_a ? resp_tag_q : '0;
        b_ack_o      = ack_b;
        b_error_o    = ack_b && resp_err_q;
        b_data_rd_o  = ack_b ? rdata : '0;
        b_resp_tag_o = ack_b ? resp_tag_q : '0;
    end

endmodule
